complex_divider: RTL and testbench

COMPLEX_DIVIDER -- requirements
Module: complex_divider

---
 rtl/cdiv_pkg.sv | 40 ++++
 rtl/udiv_serial.sv | 65 ++++++
 rtl/complex_divider.sv | 157 +++++++++++++++
 tb/tb_complex_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdiv_pkg.sv
// Shared definitions for the complex divider.
// Holds the datapath widths, the iteration count of the serial dividers,
// the FSM state encoding, the saturation limits, and the helper that turns
// an unsigned quotient magnitude plus a sign into a clamped signed result.
package cdiv_pkg;

  localparam int NUM_W  = 16;           // numerator / quotient part width
  localparam int DEN_W  = 8;            // divisor part width
  localparam int PROD_W = 26;           // signed cross-product width
  localparam int ITER   = 25;           // quotient bits per serial divide
  localparam int DVD_W  = ITER;         // unsigned dividend width (|P|, |Q|)
  localparam int DVS_W  = 16;           // unsigned divisor width (D)
  localparam int ITER_W = $clog2(ITER);

  localparam logic [NUM_W-1:0] SAT_MAX = 16'h7FFF;  //  32767
  localparam logic [NUM_W-1:0] SAT_MIN = 16'h8000;  // -32768

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Returns {sat, value}. A negative result may reach magnitude 32768 before
  // clamping, a positive one only 32767.
  function automatic logic [NUM_W:0] sign_sat(input logic [DVD_W-1:0] mag,
                                               input logic neg);
    logic [NUM_W:0] res;
    if (!neg) begin
      if (mag > DVD_W'(SAT_MAX)) res = {1'b1, SAT_MAX};
      else                       res = {1'b0, mag[NUM_W-1:0]};
    end else begin
      if (mag > DVD_W'(SAT_MIN)) res = {1'b1, SAT_MIN};
      else                       res = {1'b0, ~mag[NUM_W-1:0] + NUM_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/udiv_serial.sv
// Serial restoring unsigned divider, 25-bit dividend by 16-bit divisor.
// One quotient bit per step. The iteration count lives in the caller, which
// pulses 'step' once per bit and raises 'last' on the final one.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 load dividend/divisor, clear remainder
//   step, last            advance one bit; 'last' marks the final bit
//   dividend, divisor     operands sampled on start
//   busy                  between start and the final step
//   done                  quotient valid, held until the next start
//   quotient              result (truncated)
module udiv_serial
  import cdiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] quo;
  logic [DVS_W-1:0] dvs;

  // Remainder is always below the divisor, so the shifted trial value needs
  // just one extra bit; when it is >= divisor, the difference fits in DVS_W.
  logic [DVS_W:0]   trial;
  logic             ge;
  logic [DVS_W-1:0] diff;

  assign trial    = {rem, quo[DVD_W-1]};
  assign ge       = trial >= {1'b0, dvs};
  assign diff     = trial[DVS_W-1:0] - dvs;
  assign quotient = quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (step && busy) begin
      rem <= ge ? diff : trial[DVS_W-1:0];
      quo <= {quo[DVD_W-2:0], ge};
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_divider.sv
// Complex divider: (num_real + j*num_imag) / (den_real + j*den_imag).
// Computes P = nr*dr + ni*di, Q = ni*dr - nr*di, D = dr^2 + di^2 in one
// MULT cycle, then runs two serial dividers on |P|/D and |Q|/D for 25
// cycles, reapplies signs and clamps to 16 bits.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid stays 1, with its data
// frozen, until out_ready is seen; neither side may retract nothing.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             operand handshake
//   num_real/num_imag (16 signed) numerator
//   den_real/den_imag (8 signed)  divisor
//   out_valid/out_ready           result handshake
//   quo_real/quo_imag (16 signed) quotient
//   div_zero, sat                 flags qualified by out_valid
module complex_divider
  import cdiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] num_real,
  input  logic [NUM_W-1:0] num_imag,
  input  logic [DEN_W-1:0] den_real,
  input  logic [DEN_W-1:0] den_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] quo_real,
  output logic [NUM_W-1:0] quo_imag,
  output logic             div_zero,
  output logic             sat
);

  state_t state, state_nxt;

  logic [NUM_W-1:0]  nr_q, ni_q;
  logic [DEN_W-1:0]  dr_q, di_q;
  logic              p_neg, q_neg, dz_q;
  logic [ITER_W-1:0] iter;

  // Sign-extended operands for the MULT cycle.
  logic signed [PROD_W-1:0] nr_x, ni_x, dr_x, di_x, p, q;
  logic signed [DVS_W-1:0]  dr_s, di_s;
  logic [DVS_W-1:0]         d;
  logic [DVD_W-1:0]         p_abs, q_abs;
  logic                     dz_comb;

  assign nr_x = {{(PROD_W-NUM_W){nr_q[NUM_W-1]}}, nr_q};
  assign ni_x = {{(PROD_W-NUM_W){ni_q[NUM_W-1]}}, ni_q};
  assign dr_x = {{(PROD_W-DEN_W){dr_q[DEN_W-1]}}, dr_q};
  assign di_x = {{(PROD_W-DEN_W){di_q[DEN_W-1]}}, di_q};
  assign dr_s = {{(DVS_W-DEN_W){dr_q[DEN_W-1]}}, dr_q};
  assign di_s = {{(DVS_W-DEN_W){di_q[DEN_W-1]}}, di_q};

  assign p = nr_x * dr_x + ni_x * di_x;
  assign q = ni_x * dr_x - nr_x * di_x;
  // Each square is at most 16384 and the sum at most 32768, so 16-bit
  // arithmetic is exact.
  assign d = dr_s * dr_s + di_s * di_s;

  // |P|, |Q| never exceed 2^23, so the low 25 bits hold the magnitude.
  assign p_abs   = p[PROD_W-1] ? (~p[DVD_W-1:0] + DVD_W'(1)) : p[DVD_W-1:0];
  assign q_abs   = q[PROD_W-1] ? (~q[DVD_W-1:0] + DVD_W'(1)) : q[DVD_W-1:0];
  assign dz_comb = (dr_q == '0) && (di_q == '0);

  logic             start, step, last;
  logic             re_busy, im_busy, re_done, im_done;
  logic [DVD_W-1:0] re_quo, im_quo;
  logic [NUM_W:0]   re_res, im_res;

  assign start  = (state == MULT) && !dz_comb;
  assign step   = (state == DIV) && re_busy && im_busy;
  assign last   = (iter == ITER_W'(ITER - 1));
  assign re_res = sign_sat(re_quo, p_neg);
  assign im_res = sign_sat(im_quo, q_neg);

  udiv_serial u_div_re (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .last(last),
    .dividend(p_abs), .divisor(d),
    .busy(re_busy), .done(re_done), .quotient(re_quo)
  );

  udiv_serial u_div_im (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .last(last),
    .dividend(q_abs), .divisor(d),
    .busy(im_busy), .done(im_done), .quotient(im_quo)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MULT;
      MULT: state_nxt = dz_comb ? DONE : DIV;
      DIV:  if (step && last) state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Entering DONE on the final divide step leaves one cycle to form the
  // signed/clamped result into the output registers, which is also what
  // puts out_valid on accept+27 (accept+2 for a zero divisor).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr_q      <= '0;
      ni_q      <= '0;
      dr_q      <= '0;
      di_q      <= '0;
      p_neg     <= 1'b0;
      q_neg     <= 1'b0;
      dz_q      <= 1'b0;
      iter      <= '0;
      out_valid <= 1'b0;
      quo_real  <= '0;
      quo_imag  <= '0;
      div_zero  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          nr_q <= num_real;
          ni_q <= num_imag;
          dr_q <= den_real;
          di_q <= den_imag;
        end
        MULT: begin
          p_neg <= p[PROD_W-1];
          q_neg <= q[PROD_W-1];
          dz_q  <= dz_comb;
          iter  <= '0;
        end
        DIV: if (step) iter <= iter + ITER_W'(1);
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end else if (!out_valid && (dz_q || (re_done && im_done))) begin
            out_valid <= 1'b1;
            div_zero  <= dz_q;
            quo_real  <= dz_q ? '0 : re_res[NUM_W-1:0];
            quo_imag  <= dz_q ? '0 : im_res[NUM_W-1:0];
            sat       <= dz_q ? 1'b0 : (re_res[NUM_W] | im_res[NUM_W]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider: vector table with hand-computed
// quotients, plus hand-written sequences for reset abort and output stall.
module tb_complex_divider;

  localparam int RES_W = 34;  // {quo_real, quo_imag, div_zero, sat}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] num_real, num_imag;
  logic [7:0]  den_real, den_imag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quo_real, quo_imag;
  logic        div_zero, sat;

  complex_divider dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .num_real(num_real), .num_imag(num_imag),
    .den_real(den_real), .den_imag(den_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .quo_real(quo_real), .quo_imag(quo_imag),
    .div_zero(div_zero), .sat(sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic compare_out(input string tag);
    logic [RES_W-1:0] act, exp;
    act = {quo_real, quo_imag, div_zero, sat};
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got 0x%0h, required an expected entry (queue empty)", tag, act);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 64'(act), 64'(exp));
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] nr, ni;
    logic [7:0]  dr, di;
    logic [15:0] er, ei;
    logic        dz, st;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // ---------------- driver tasks ----------------
  // Presents one operand set, returns #1 after the accept edge.
  task automatic send(input vec_t v, input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    num_real = v.nr;
    num_imag = v.ni;
    den_real = v.dr;
    den_imag = v.di;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands changing after acceptance must not disturb the result.
    num_real = 16'($urandom);
    num_imag = 16'($urandom);
    den_real = 8'($urandom);
    den_imag = 8'($urandom);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
  endtask

  // Counts rising edges after accept until out_valid, bounded.
  task automatic wait_result(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [RES_W-1:0] held;
    logic             stable;
    int               rises;

    vecs[0]  = '{-16'sd7,     16'sd22,     8'sd4,   8'sd5,   16'sd2,    16'sd3,     1'b0, 1'b0, 27};
    vecs[1]  = '{16'sd0,      16'sd2,      8'sd1,   8'sd1,   16'sd1,    16'sd1,     1'b0, 1'b0, 27};
    vecs[2]  = '{-16'sd3,     16'sd4,      8'sd1,   8'sd2,   16'sd1,    16'sd2,     1'b0, 1'b0, 27};
    vecs[3]  = '{-16'sd5,     16'sd5,      8'sd2,   8'sd0,   -16'sd2,   16'sd2,     1'b0, 1'b0, 27};
    vecs[4]  = '{16'sd32767,  16'h8000,    8'sd1,   8'sd1,   16'sd0,    -16'sd32767, 1'b0, 1'b0, 27};
    vecs[5]  = '{16'h8000,    16'sd0,      -8'sd1,  8'sd0,   16'sd32767, 16'sd0,    1'b0, 1'b1, 27};
    vecs[6]  = '{16'sd100,    16'sd100,    8'sd0,   8'sd0,   16'sd0,    16'sd0,     1'b1, 1'b0, 2};
    vecs[7]  = '{16'h8000,    16'sd0,      8'sd0,   8'sd1,   16'sd0,    16'sd32767, 1'b0, 1'b1, 27};
    vecs[8]  = '{16'sd32767,  16'sd32767,  8'sd1,   -8'sd1,  16'sd0,    16'sd32767, 1'b0, 1'b0, 27};
    vecs[9]  = '{16'h8000,    16'h8000,    8'sd1,   -8'sd1,  16'sd0,    16'h8000,   1'b0, 1'b0, 27};
    vecs[10] = '{16'sd32767,  16'sd32767,  8'h80,   8'h80,   -16'sd255, 16'sd0,     1'b0, 1'b0, 27};
    vecs[11] = '{16'sd0,      16'sd0,      8'sd0,   8'sd0,   16'sd0,    16'sd0,     1'b1, 1'b0, 2};
    vecs[12] = '{16'sd1000,   16'sd0,      8'sd0,   8'sd1,   16'sd0,    -16'sd1000, 1'b0, 1'b0, 27};
    vecs[13] = '{16'sd7,      16'sd0,      8'sd3,   8'sd0,   16'sd2,    16'sd0,     1'b0, 1'b0, 27};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    num_real  = '0;
    num_imag  = '0;
    den_real  = '0;
    den_imag  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({quo_real, quo_imag, div_zero, sat}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'({in_ready, out_valid}), 64'b10);

    // Table: out_ready tied 1, so consecutive rows go back-to-back.
    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      exp_q.push_back({vecs[i].er, vecs[i].ei, vecs[i].dz, vecs[i].st});
      send(vecs[i], tag);
      wait_result(vecs[i].lat, tag);
      compare_out({tag, "_result"});
      @(posedge clk);
      #1;
      check({tag, "_handshake"}, 64'({in_ready, out_valid}), 64'b10);
    end

    // Reset in the middle of the divide: the result is never presented.
    send(vecs[0], "abort");
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_outputs", 64'({out_valid, quo_real, quo_imag, div_zero, sat}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) rises++;
    end
    check("abort_no_result", 64'(rises), 64'd0);
    check("abort_idle", 64'(in_ready), 64'd1);

    // Output stall of 50 cycles with a competing operand set offered.
    out_ready = 1'b0;
    exp_q.push_back({vecs[13].er, vecs[13].ei, vecs[13].dz, vecs[13].st});
    send(vecs[13], "stall");
    wait_result(27, "stall");
    compare_out("stall_result");
    held   = {quo_real, quo_imag, div_zero, sat};
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      num_real = 16'sd100;
      num_imag = 16'sd100;
      den_real = 8'sd0;
      den_imag = 8'sd0;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || ({quo_real, quo_imag, div_zero, sat} !== held))
        stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", 64'({in_ready, out_valid}), 64'b10);
    rises = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) rises++;
    end
    check("stall_ignored_input", 64'(rises), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
